// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: turns bytes from an SPI slave into complete MIDI
// messages (status + up to two data bytes), with running status, SysEx
// skipping, real-time passthrough and a one-deep valid/ready output holding
// register with a sticky overflow flag.
module midi_msg_parser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic                  rdy_i,
  output logic [7:0]            msg_status,
  output logic [7:0]            msg_d1,
  output logic [7:0]            msg_d2,
  output logic [1:0]            msg_len,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_D1 = 2'd1,
    S_WAIT_D2 = 2'd2,
    S_SYSEX   = 2'd3
  } state_t;

  // Byte-ready synchroniser and edge detector
  logic       sync1_q, sync2_q;
  logic       prev_q;
  logic [1:0] fill_q;
  logic       rdy_rise;

  // Parser state
  state_t     state_q, state_d;
  logic [7:0] rs_q, rs_d;
  logic [7:0] cur_q, cur_d;
  logic [7:0] d1_q, d1_d;

  // Message completed by the byte accepted this cycle
  logic       cmp_d;
  logic [7:0] cmp_status_d, cmp_d1_d, cmp_d2_d;
  logic [1:0] cmp_len_d;

  // Output holding register
  logic [7:0] msg_status_q, msg_d1_q, msg_d2_q;
  logic [1:0] msg_len_q;
  logic       msg_valid_q;
  logic       ovf_q;

  logic [7:0] in_byte;
  logic       cur_is_chan;
  logic       cur_one_data;
  logic       load_msg;
  logic       drop_msg;

  assign in_byte = byte_i[7:0];

  // The previous-sample flop reads as 1 until two genuine samples have
  // passed through the synchroniser, so rdy_i held high across reset
  // release never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b1;
      fill_q  <= 2'd0;
    end else begin
      sync1_q <= rdy_i;
      sync2_q <= sync1_q;
      if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      prev_q  <= (fill_q == 2'd2) ? sync2_q : 1'b1;
    end
  end

  assign rdy_rise = sync2_q & ~prev_q;

  // Channel messages keep running status; system-common ones return to IDLE.
  assign cur_is_chan  = (cur_q < 8'hF0);
  assign cur_one_data = (cur_q[7:5] == 3'b110) || (cur_q == 8'hF1) || (cur_q == 8'hF3);

  // Next-state decode for the accepted byte and the message it may complete
  always_comb begin
    state_d      = state_q;
    rs_d         = rs_q;
    cur_d        = cur_q;
    d1_d         = d1_q;
    cmp_d        = 1'b0;
    cmp_status_d = 8'h00;
    cmp_d1_d     = 8'h00;
    cmp_d2_d     = 8'h00;
    cmp_len_d    = 2'd0;
    if (rdy_rise) begin
      if (in_byte >= 8'hF8) begin
        // Real-time: emitted on its own, parser context untouched
        cmp_d        = 1'b1;
        cmp_status_d = in_byte;
      end else if (in_byte[7]) begin
        if (in_byte < 8'hF0) begin
          rs_d    = in_byte;
          cur_d   = in_byte;
          state_d = S_WAIT_D1;
        end else begin
          rs_d = 8'h00;
          case (in_byte)
            8'hF0: state_d = S_SYSEX;
            8'hF1, 8'hF2, 8'hF3: begin
              cur_d   = in_byte;
              state_d = S_WAIT_D1;
            end
            8'hF6: begin
              cmp_d        = 1'b1;
              cmp_status_d = in_byte;
              state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end else begin
        case (state_q)
          S_WAIT_D1: begin
            d1_d = in_byte;
            if (cur_one_data) begin
              cmp_d        = 1'b1;
              cmp_status_d = cur_q;
              cmp_d1_d     = in_byte;
              cmp_len_d    = 2'd1;
              state_d      = cur_is_chan ? S_WAIT_D1 : S_IDLE;
            end else begin
              state_d = S_WAIT_D2;
            end
          end
          S_WAIT_D2: begin
            cmp_d        = 1'b1;
            cmp_status_d = cur_q;
            cmp_d1_d     = d1_q;
            cmp_d2_d     = in_byte;
            cmp_len_d    = 2'd2;
            state_d      = cur_is_chan ? S_WAIT_D1 : S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign load_msg = cmp_d & (~msg_valid_q | msg_ready);
  assign drop_msg = cmp_d & msg_valid_q & ~msg_ready;

  // Parser FSM plus registered message outputs and overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rs_q         <= 8'h00;
      cur_q        <= 8'h00;
      d1_q         <= 8'h00;
      msg_status_q <= 8'h00;
      msg_d1_q     <= 8'h00;
      msg_d2_q     <= 8'h00;
      msg_len_q    <= 2'd0;
      msg_valid_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      cur_q   <= cur_d;
      d1_q    <= d1_d;
      if (load_msg) begin
        msg_status_q <= cmp_status_d;
        msg_d1_q     <= cmp_d1_d;
        msg_d2_q     <= cmp_d2_d;
        msg_len_q    <= cmp_len_d;
        msg_valid_q  <= 1'b1;
      end else if (msg_ready) begin
        msg_valid_q  <= 1'b0;
      end
      // A fresh drop wins over a clear in the same cycle
      ovf_q <= (ovf_q & ~ovf_clr) | drop_msg;
    end
  end

  assign msg_status = msg_status_q;
  assign msg_d1     = msg_d1_q;
  assign msg_d2     = msg_d2_q;
  assign msg_len    = msg_len_q;
  assign msg_valid  = msg_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Testbench for midi_msg_parser: directed byte sequences, a message-level
// reference model with an expected-message queue, and literal spot checks.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       rdy_i = 1'b0;
  logic [7:0] msg_status, msg_d1, msg_d2;
  logic [1:0] msg_len;
  logic       msg_valid;
  logic       msg_ready = 1'b1;
  logic       ovf;
  logic       ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b1;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [1:0] len;
  } msg_t;

  msg_t exp_q[$];
  msg_t log_q[$];

  // Reference model context: status being collected, bytes still needed
  bit         m_collect = 1'b0;
  logic [7:0] m_stat = 8'h00;
  int         m_need = 0;
  logic [7:0] m_data[$];

  midi_msg_parser #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .rdy_i(rdy_i),
    .msg_status(msg_status), .msg_d1(msg_d1), .msg_d2(msg_d2),
    .msg_len(msg_len), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic msg_t mk(input logic [7:0] st, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [1:0] len);
    msg_t m;
    m.st = st; m.d1 = d1; m.d2 = d2; m.len = len;
    return m;
  endfunction

  // Message-level model: what message (if any) each byte produces
  function automatic void model_byte(input logic [7:0] b);
    msg_t m;
    if (b >= 8'hF8) begin
      exp_q.push_back(mk(b, 8'h00, 8'h00, 2'd0));
    end else if (b >= 8'h80) begin
      m_data.delete();
      m_collect = 1'b0;
      if (b < 8'hF0) begin
        m_collect = 1'b1; m_stat = b;
        m_need = (b[7:4] == 4'hC || b[7:4] == 4'hD) ? 1 : 2;
      end else if (b == 8'hF1 || b == 8'hF3) begin
        m_collect = 1'b1; m_stat = b; m_need = 1;
      end else if (b == 8'hF2) begin
        m_collect = 1'b1; m_stat = b; m_need = 2;
      end else if (b == 8'hF6) begin
        exp_q.push_back(mk(b, 8'h00, 8'h00, 2'd0));
      end
    end else if (m_collect) begin
      m_data.push_back(b);
      if (m_data.size() == m_need) begin
        m = mk(m_stat, m_data[0], (m_need == 2) ? m_data[1] : 8'h00, 2'(m_need));
        exp_q.push_back(m);
        m_data.delete();
        if (m_stat >= 8'hF0) m_collect = 1'b0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_collect = 1'b0;
    m_data.delete();
  endfunction

  // Compare every handshaked message with the model's next expectation
  always @(negedge clk) begin
    msg_t got, e;
    if (cmp_en && rst && msg_valid && msg_ready) begin
      got = mk(msg_status, msg_d1, msg_d2, msg_len);
      log_q.push_back(got);
      if (exp_q.size() == 0) begin
        chk("unexpected_msg", {22'd0, got}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("msg", {22'd0, got}, {22'd0, e});
      end
      $display("msg st=%02h d1=%02h d2=%02h len=%0d", got.st, got.d1, got.d2, got.len);
    end
  end

  task automatic send(input logic [7:0] b);
    model_byte(b);
    @(posedge clk); #1;
    byte_i = b; rdy_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 rdy_i = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_list(input logic [7:0] bl[$]);
    log_q.delete();
    foreach (bl[i]) send(bl[i]);
    repeat (4) @(posedge clk);
    chk("pending_msgs", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", msg_valid, 0);
    chk("rst_status", msg_status, 0);
    chk("rst_d1d2", {msg_d1, msg_d2}, 0);
    chk("rst_len", msg_len, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    do_reset();

    // Note on / running status
    send_list('{8'h90, 8'h3C, 8'h64});
    chk("t1_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("t1_status", log_q[0].st, 8'h90);
      chk("t1_d1", log_q[0].d1, 8'h3C);
      chk("t1_d2", log_q[0].d2, 8'h64);
      chk("t1_len", log_q[0].len, 2);
    end
    send_list('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h00});
    chk("t2_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t2_status", log_q[1].st, 8'h90);
      chk("t2_d1d2", {log_q[1].d1, log_q[1].d2}, 16'h4000);
    end
    send_list('{8'hC5, 8'h07, 8'h08});
    chk("t3_count", log_q.size(), 2);
    if (log_q.size() >= 2) chk("t3_second", {log_q[1].st, log_q[1].d1, 6'd0, log_q[1].len}, 24'hC50801);

    // Real-time interleaved mid-message
    send_list('{8'h90, 8'h3C, 8'hF8, 8'h64});
    chk("t4_count", log_q.size(), 2);
    if (log_q.size() >= 2) begin
      chk("t4_first", log_q[0].st, 8'hF8);
      chk("t4_second", {log_q[1].st, log_q[1].d1, log_q[1].d2}, 24'h903C64);
    end

    // SysEx and undefined status produce nothing
    send_list('{8'hF0, 8'h01, 8'h02, 8'hF7, 8'h45});
    chk("t5_count", log_q.size(), 0);

    // System common, other channel classes, status interruption
    send_list('{8'hF2, 8'h11, 8'h22, 8'h33, 8'hF1, 8'h05, 8'hF3, 8'h7F, 8'h7E});
    chk("t6_count", log_q.size(), 3);
    send_list('{8'hD3, 8'h10, 8'hE0, 8'h01, 8'h02, 8'h90, 8'h3C, 8'hB0, 8'h07, 8'h08, 8'hF4, 8'h10});
    chk("t7_count", log_q.size(), 3);

    // Reset mid-message discards partial data
    send_list('{8'h90, 8'h3C});
    do_reset();
    send_list('{8'h64, 8'h3C, 8'h91, 8'h40, 8'h50});
    chk("t8_count", log_q.size(), 1);

    // rdy_i held high across reset release must not produce a byte
    @(posedge clk); #1 rst = 1'b0; byte_i = 8'hF8; rdy_i = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    log_q.delete();
    repeat (12) @(posedge clk);
    #1 rdy_i = 1'b0;
    repeat (4) @(posedge clk);
    chk("t9_no_msg", log_q.size(), 0);

    // Back-pressure and overflow
    cmp_en = 1'b0;
    @(posedge clk); #1 msg_ready = 1'b0;
    send(8'hF6);
    send(8'hFE);
    @(negedge clk);
    chk("ovf_valid", msg_valid, 1);
    chk("ovf_status", msg_status, 8'hF6);
    chk("ovf_len", msg_len, 0);
    chk("ovf_set", ovf, 1);
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf, 0);
    chk("ovf_held_status", msg_status, 8'hF6);
    // Clear coinciding with a new drop leaves the flag set
    @(posedge clk); #1 byte_i = 8'hF8; rdy_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 ovf_clr = 1'b1;
    @(posedge clk); #1 ovf_clr = 1'b0; rdy_i = 1'b0;
    @(negedge clk);
    chk("ovf_clr_collide", ovf, 1);
    chk("ovf_held_status2", msg_status, 8'hF6);
    @(posedge clk); #1 msg_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain_valid", msg_valid, 0);
    exp_q.delete();
    cmp_en = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/midi_msg_parser.md
MIDI_MSG_PARSER -- requirements
Module: midi_msg_parser

Interface
REQ-001 Parameter: DATA_WIDTH, 8, byte width from the SPI slave; only 8 is supported.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 byte_i  input  8  received byte; connects to the spislave_wr data_o output.
REQ-005 rdy_i  input  1  byte-ready; connects to the spislave_wr rdy output; level or pulse.
REQ-006 msg_status  output  8  status byte of the completed message.
REQ-007 msg_d1  output  8  first data byte; 0x00 if unused.
REQ-008 msg_d2  output  8  second data byte; 0x00 if unused.
REQ-009 msg_len  output  2  number of data bytes (0..2).
REQ-010 msg_valid  output  1  message held on the msg_* outputs.
REQ-011 msg_ready  input  1  consumer accepts the message.
REQ-012 ovf  output  1  sticky flag: a completed message was dropped.
REQ-013 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-014 A byte shall be accepted exactly once, on the first clk cycle after rdy_i is sampled as 1 when it was 0 on the previous sample (rising-edge detect through a 2-flop synchroniser); latency from the rdy_i edge to the parser state update is 3 clk.
REQ-015 Parser states shall be IDLE (no running status), WAIT_D1, WAIT_D2 and SYSEX; a running-status register rs holds the last channel status byte.
REQ-016 A channel status byte (0x80-0xEF) shall load rs and move to WAIT_D1.
REQ-017 In WAIT_D1, a data byte (bit7=0) shall be stored as d1; then, for status classes 0xC/0xD, the message completes with len=1, otherwise the state moves to WAIT_D2.
REQ-018 In WAIT_D2, a data byte shall complete the message with len=2, and the state returns to WAIT_D1 with rs retained (running status).
REQ-019 In IDLE or SYSEX, data bytes shall be discarded.
REQ-020 A status byte of 0xF1 or 0xF3 shall expect 1 data byte, 0xF2 shall expect 2, and 0xF6 shall complete immediately with len=0; all of these clear rs, and the state goes to IDLE after completion.
REQ-021 A status byte of 0xF4, 0xF5 or 0xF7 shall clear rs and go to IDLE without emitting a message.
REQ-022 A status byte of 0xF0 shall clear rs and enter SYSEX; any status byte other than real-time exits SYSEX and is processed normally.
REQ-023 Real-time bytes (0xF8-0xFF) shall complete immediately with len=0, and shall not change the state, rs or any partial data.
REQ-024 On completion, if msg_valid=0 or msg_ready=1 in the same cycle, the msg_* outputs shall load and msg_valid=1 on the next clk.
REQ-025 On completion with msg_valid=1 and msg_ready=0, the new message shall be dropped, ovf shall be set to 1, and the held message shall be unchanged.
REQ-026 msg_valid shall clear on the clk after msg_valid=1 and msg_ready=1, unless a new message loads in that same cycle.
REQ-027 msg_* shall stay stable while msg_valid=1 and msg_ready=0.
REQ-028 ovf_clr and a new overflow in the same cycle shall leave ovf=1.

Reset
REQ-029 While rst=0, the block shall be in state IDLE with rs=0x00, both synchroniser flops at 0, msg_status/msg_d1/msg_d2=0x00, msg_len=0, msg_valid=0 and ovf=0.
REQ-030 Reset asserted mid-message shall discard partial data; after release, data bytes are ignored until a status byte arrives.
REQ-031 rdy_i held at 1 across reset release shall not produce an accepted byte.

Verification
REQ-032 Stimulus 0x90,0x3C,0x64 with msg_ready=1 -> one message: status=0x90, d1=0x3C, d2=0x64, len=2.
REQ-033 Stimulus 0x90,0x3C,0x64,0x40,0x00 -> two messages, both with status 0x90; the second has d1=0x40, d2=0x00.
REQ-034 Stimulus 0xC5,0x07,0x08 -> two messages, 0xC5/0x07 and 0xC5/0x08, each with len=1.
REQ-035 Stimulus 0x90,0x3C,0xF8,0x64 -> message 0xF8 (len=0) first, then 0x90/0x3C/0x64.
REQ-036 Stimulus 0xF0,0x01,0x02,0xF7,0x45 -> no messages emitted.
REQ-037 msg_ready=0 with stimulus 0xF6,0xFE -> held message 0xF6, ovf=1; after ovf_clr -> ovf=0 and msg_status still 0xF6.
